// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier: one multiplier bit per CALC cycle,
// fixed WIDTH-cycle latency, unsigned or two's-complement operands,
// valid/ready handshake on both the request and the result side.
module shift_add_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               signed_mode,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [PW-1:0]    w_addend;
    logic [PW-1:0]    w_acc_next;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // Negating the most negative value wraps to 100..0, which read as
    // unsigned is exactly the required magnitude 2^(WIDTH-1).
    assign w_a_mag = (signed_mode && A[WIDTH-1]) ? -A : A;
    assign w_b_mag = (signed_mode && B[WIDTH-1]) ? -B : B;

    // The multiplier register shifts right each cycle, so bit 0 is always
    // the bit selected by the counter.
    assign w_addend   = r_mplier[0] ? ({{WIDTH{1'b0}}, r_mcand} << r_cnt) : '0;
    assign w_acc_next = r_acc + w_addend;

    assign result = r_result;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next_state = CALC;
            CALC:    if (w_last)    w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default:                w_next_state = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state
    always_comb begin
        in_ready  = (r_state == IDLE);
        busy      = (r_state != IDLE);
        out_valid = (r_state == DONE);
    end

    // Operand capture, accumulation and final sign correction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
        end else if (w_accept) begin
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_neg    <= signed_mode && (A[WIDTH-1] ^ B[WIDTH-1]);
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == CALC) begin
            r_acc    <= w_acc_next;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_result <= r_neg ? -w_acc_next : w_acc_next;
            end
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and randomized bench for shift_add_multiplier at WIDTH = 4.
module tb_shift_add_multiplier;

    localparam int unsigned W = 4;

    logic           clk;
    logic           rst_n;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           signed_mode;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] result;
    logic           out_valid;
    logic           out_ready;
    logic           busy;

    int checks = 0;
    int errors = 0;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .A           (A),
        .B           (B),
        .signed_mode (signed_mode),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .result      (result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product computed with plain integer arithmetic.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sm);
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
        if (sm) begin
            if (sa >= (1 << (W - 1))) sa = sa - (1 << W);
            if (sb >= (1 << (W - 1))) sb = sb - (1 << W);
        end
        return (2*W)'(sa * sb);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, scramble the inputs while it is in flight, and
    // check latency and product. With out_ready high, also check that the
    // result is a single-cycle pulse.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                          input string tag);
        int n;
        logic [2*W-1:0] exp;
        exp = model(a, b, sm);
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, 64'(in_ready), 64'(1));
        A           = a;
        B           = b;
        signed_mode = sm;
        in_valid    = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            A           = W'($urandom);
            B           = W'($urandom);
            signed_mode = 1'($urandom);
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(4));
        chk({tag, "_result"}, 64'(result), 64'(exp));
        if (out_ready) begin
            tick();
            chk({tag, "_pulse"}, 64'(out_valid), 64'(0));
        end
    endtask

    initial begin
        logic [2*W-1:0] held;
        int unsigned    k;
        int unsigned    off;
        int             n;

        rst_n       = 1'b0;
        A           = '0;
        B           = '0;
        signed_mode = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        #2;
        chk("rst_result",    64'(result),    64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy",      64'(busy),      64'(0));
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic latency case
        run_op(4'b0010, 4'b0001, 1'b0, "u_2x1");
        chk("u_2x1_const", 64'(model(4'b0010, 4'b0001, 1'b0)), 64'(8'h02));

        // Back-to-back unsigned with out_ready tied high
        run_op(4'b1111, 4'b1010, 1'b0, "u_15x10");
        run_op(4'b0101, 4'b0011, 1'b0, "u_5x3");

        // Signed corner cases
        run_op(4'b1111, 4'b1010, 1'b1, "s_m1xm6");
        run_op(4'b1000, 4'b1000, 1'b1, "s_m8xm8");
        run_op(4'b0111, 4'b1000, 1'b1, "s_7xm8");

        // Backpressure: hold DONE for 5 cycles with a competing request
        out_ready = 1'b0;
        run_op(4'b1011, 4'b0110, 1'b0, "bp");
        held = result;
        A           = 4'b0001;
        B           = 4'b0001;
        signed_mode = 1'b0;
        in_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_result",    64'(result),    64'(model(4'b1011, 4'b0110, 1'b0)));
            chk("bp_stable",    64'(result),    64'(held));
            chk("bp_in_ready",  64'(in_ready),  64'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 64'(out_valid), 64'(0));
        chk("bp_release_ready", 64'(in_ready),  64'(1));
        tick();
        tick();
        chk("bp_no_queued", 64'(busy), 64'(0));

        // Reset two edges into CALC
        A           = 4'b1111;
        B           = 4'b1111;
        signed_mode = 1'b0;
        in_valid    = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("ar_busy_before", 64'(busy), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_result",    64'(result),    64'(0));
        chk("ar_out_valid", 64'(out_valid), 64'(0));
        chk("ar_busy",      64'(busy),      64'(0));
        chk("ar_in_ready",  64'(in_ready),  64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) n++;
        end
        chk("ar_no_pulse", 64'(n), 64'(0));
        run_op(4'b0011, 4'b0011, 1'b0, "ar_3x3");

        // Randomized full sweeps: a random odd stride visits every pair once
        for (int m = 0; m < 2; m++) begin
            k   = ($urandom % 128) * 2 + 1;
            off = $urandom % 256;
            for (int i = 0; i < 256; i++) begin
                logic [7:0] idx;
                idx = 8'((i * k + off) % 256);
                run_op(idx[7:4], idx[3:0], 1'(m), m == 0 ? "sweep_u" : "sweep_s");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-004 The block SHALL have port A, input, WIDTH bits, the multiplicand, sampled at acceptance.
REQ-005 The block SHALL have port B, input, WIDTH bits, the multiplier, sampled at acceptance.
REQ-006 The block SHALL have port signed_mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled at acceptance.
REQ-007 The block SHALL have port in_valid, input, 1 bit, indicating the operand request is valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit, indicating the block can accept a request.
REQ-009 The block SHALL have port result, output, 2*WIDTH bits, the product.
REQ-010 The block SHALL have port out_valid, output, 1 bit, indicating result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit, indicating the consumer accepts result.
REQ-012 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-013 The block SHALL implement the states IDLE, CALC and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; acceptance SHALL occur on a rising edge where in_valid && in_ready.
REQ-015 On acceptance the block SHALL latch the operands and mode, clear the accumulator, zero the bit counter and enter CALC.
REQ-016 In signed mode the block SHALL latch the absolute values of A and B plus a negate flag equal to A[MSB] XOR B[MSB]; the value -2^(WIDTH-1) SHALL map to the unsigned magnitude 2^(WIDTH-1).
REQ-017 Each CALC edge SHALL process one multiplier bit, LSB first: when that bit is 1, add the multiplicand shifted left by the counter value into the 2*WIDTH-bit accumulator; then increment the counter.
REQ-018 On the WIDTH-th CALC edge the block SHALL enter DONE, assert out_valid and drive result, two's-complement negated when the negate flag is set.
REQ-019 Latency SHALL be fixed: out_valid rises exactly WIDTH rising edges after the accepting edge, with no early termination on zero operands.
REQ-020 In DONE, result and out_valid SHALL hold stable until an edge where out_ready = 1; on that edge the block SHALL return to IDLE with out_valid = 0.
REQ-021 out_ready high before or during DONE entry SHALL give a 1-cycle out_valid pulse; a new request SHALL be accepted no earlier than the edge after that.
REQ-022 in_valid SHALL be ignored while in CALC or DONE, with no request queued.
REQ-023 Changes on A, B or signed_mode after acceptance SHALL NOT affect the result in flight.
REQ-024 Arithmetic SHALL be exact: an unsigned product is at most (2^WIDTH-1)^2 and a signed product lies in [-(2^(WIDTH-1))(2^(WIDTH-1)-1), 2^(2*WIDTH-2)]; no overflow or truncation SHALL occur.

Reset
REQ-025 rst_n low SHALL immediately, independent of clk, force IDLE, with result = 0, out_valid = 0, busy = 0, in_ready = 1, and the accumulator, counter and negate flag cleared.
REQ-026 Reset asserted during CALC or DONE SHALL abort the operation with no out_valid pulse; after release the first accepted request SHALL complete normally.

Verification (WIDTH = 4)
REQ-027 A bench SHALL check unsigned A=0010, B=0001 -> result 0x02, with out_valid exactly 4 edges after acceptance.
REQ-028 A bench SHALL check unsigned A=1111, B=1010 -> 0x96, and unsigned A=0101, B=0011 -> 0x0F, issued back-to-back with out_ready tied high.
REQ-029 A bench SHALL check signed A=1111 (-1), B=1010 (-6) -> 0x06; signed A=1000, B=1000 -> 0x40; signed A=0111, B=1000 -> 0xC8 (-56).
REQ-030 A bench SHALL check backpressure: out_ready held low 5 cycles in DONE -> result and out_valid stable, in_ready = 0, and a concurrent in_valid is not accepted.
REQ-031 A bench SHALL check reset asserted 2 edges into CALC -> outputs at reset values at once, no out_valid; then A=0011, B=0011 -> 0x09.
REQ-032 A bench SHALL run a randomized unsigned and signed sweep of all 256 operand pairs per mode against a reference model, with A and B toggled during CALC.
